// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_RECOVER
    } rx_state_t;

    localparam int SYNC_STAGES   = 2;
    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for a zero-extended data word.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_mode_t mode);
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: reloading down-counter with a divider latched on restart.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] baud_divider,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] count_q;

    // A divider of 0 behaves like 1, i.e. a tick every clock.
    function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [DIV_WIDTH-1:0] div);
        return (div == '0) ? '0 : div - DIV_WIDTH'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            count_q <= '0;
        end else if (restart) begin
            div_q   <= baud_divider;
            count_q <= reload_of(baud_divider);
        end else if (count_q == '0) begin
            count_q <= reload_of(div_q);
        end else begin
            count_q <= count_q - DIV_WIDTH'(1);
        end
    end

    assign tick = (count_q == '0) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote oversampling and a one-deep output stream.
//   state   | meaning
//   IDLE    | line idle, watching rx_s for a falling edge
//   START   | validating the start bit (high vote = false start)
//   DATA    | shifting data bits in, LSB first
//   PARITY  | sampling and checking the parity bit
//   STOP    | checking stop bits; frame commits on last stop decision
//   RECOVER | line held low after frame (break), wait for high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_divider,
    input  logic                 rx,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_bits,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_detect,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                OS_W      = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_S0     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_S1     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]   OS_DECIDE = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_mode_t      PMODE     = parity_mode_t'(2'(PARITY_MODE));

    rx_state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q;
    logic                   tick, start_det, commit, decide, bit_end, voted;
    logic [OS_W-1:0]        os_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [1:0]             samp_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q, par_err_q, frm_err_q;
    logic                   accept, commit_ferr, commit_brk;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clock        (clock),
        .reset        (reset),
        .restart      (start_det),
        .baud_divider (baud_divider),
        .tick         (tick)
    );

    assign decide  = tick && (os_cnt_q == OS_DECIDE);
    assign bit_end = tick && (os_cnt_q == OS_LAST);
    // Third sample is the live rx_s on the decision tick.
    assign voted   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    start_det = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (decide && voted) state_d = ST_IDLE;
                else if (bit_end)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt_q == DATA_LAST)
                    state_d = (PMODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Commit mid-bit so back-to-back frames are never missed.
                if (decide && bit_cnt_q == STOP_LAST) begin
                    commit  = 1'b1;
                    state_d = rx_s ? ST_IDLE : ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '1;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else if (start_det) begin
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else if (tick && state_q != ST_IDLE) begin
            os_cnt_q <= bit_end ? '0 : os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_S0) samp_q[0] <= rx_s;
            if (os_cnt_q == OS_S1) samp_q[1] <= rx_s;
            if (bit_end) bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + 4'd1;
            if (decide) begin
                case (state_q)
                    ST_DATA:   shift_q <= {voted, shift_q[DATA_BITS-1:1]};
                    ST_PARITY: begin
                        par_bit_q <= voted;
                        par_err_q <= voted != parity_of(MAX_DATA_BITS'(shift_q), PMODE);
                    end
                    ST_STOP:   if (!voted) frm_err_q <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign accept      = data_valid && data_ready;
    assign commit_ferr = frm_err_q | ~voted;
    assign commit_brk  = commit_ferr && (shift_q == '0) &&
                         ((PMODE == PARITY_NONE) || !par_bit_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            data_valid   <= 1'b0;
            data_bits    <= '0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= commit && data_valid && !accept;
            if (commit && (!data_valid || accept)) begin
                data_valid   <= 1'b1;
                data_bits    <= shift_q;
                parity_error <= par_err_q;
                frame_error  <= commit_ferr;
                break_detect <= commit_brk;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule
